line_decoder_seq: RTL and testbench



---
 rtl/line_dec_pkg.sv | 13 +
 rtl/onehot_dec.sv | 14 +
 rtl/line_decoder_seq.sv | 115 +++++++++++
 tb/tb_line_decoder_seq.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/line_dec_pkg.sv
// Shared types and constants for the sequenced line decoder.
package line_dec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SCAN
    } state_t;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Combinational AW-to-2^AW one-hot decoder.
module onehot_dec #(
    parameter int AW = 5
) (
    input  logic [AW-1:0]      addr,
    output logic [(2**AW)-1:0] lines
);

    always_comb begin
        lines       = '0;
        lines[addr] = 1'b1;
    end

endmodule

// File: rtl/line_decoder_seq.sv
// Registered line decoder with valid/ready accept, DECODE hold and SCAN sweep.
// Optional build macro LINE_DEC_ACTIVE_LOW_EN drives D inverted (idle value all ones).
module line_decoder_seq
    import line_dec_pkg::*;
#(
    parameter int AW      = 5,
    parameter int DWELL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AW-1:0]        A,
    input  logic                 mode,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic                 stop,
    output logic [(2**AW)-1:0]   D,
    output logic                 D_valid
);

    localparam int N = 2**AW;

    state_t             state;
    logic [AW-1:0]      idx;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_reg;

    logic               accept;
    logic [AW-1:0]      next_idx;
    logic [N-1:0]       next_lines;
    logic [N-1:0]       line_drive;

    assign accept = in_valid && in_ready;

    // The decoder sees the index that D will show after this edge.
    always_comb begin
        next_idx = idx;
        if (accept) begin
            next_idx = A;
        end else if (state == SCAN && cnt == '0) begin
            next_idx = idx + AW'(1);
        end
    end

    onehot_dec #(.AW(AW)) u_onehot_dec (
        .addr  (next_idx),
        .lines (next_lines)
    );

`ifdef LINE_DEC_ACTIVE_LOW_EN
    localparam logic [N-1:0] D_OFF = '1;
    assign line_drive = ~next_lines;
`else
    localparam logic [N-1:0] D_OFF = '0;
    assign line_drive = next_lines;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            dwell_reg <= '0;
            D         <= D_OFF;
            D_valid   <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx       <= A;
                        cnt       <= dwell;
                        dwell_reg <= dwell;
                        state     <= (mode == MODE_SCAN) ? SCAN : HOLD;
                        D         <= line_drive;
                        D_valid   <= 1'b1;
                        in_ready  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (stop || cnt == '0) begin
                        state    <= IDLE;
                        D        <= D_OFF;
                        D_valid  <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
                SCAN: begin
                    // stop wins over a same-cycle advance
                    if (stop) begin
                        state    <= IDLE;
                        D        <= D_OFF;
                        D_valid  <= 1'b0;
                        in_ready <= 1'b1;
                    end else if (cnt == '0) begin
                        idx <= next_idx;
                        cnt <= dwell_reg;
                        D   <= line_drive;
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    D        <= D_OFF;
                    D_valid  <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_decoder_seq.sv
// Scoreboard bench for line_decoder_seq: expected outputs queued per driven cycle, checked at negedge.
module tb_line_decoder_seq;

    typedef struct packed {
        logic [31:0] d;
        logic        dv;
        logic        rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  A;
    logic        mode;
    logic [3:0]  dwell;
    logic        stop;
    logic [31:0] D;
    logic        D_valid;

    int   assert_count = 0;
    int   fail_count   = 0;
    exp_t exp_q[$];
    exp_t cur;

    line_decoder_seq #(.AW(5), .DWELL_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .mode     (mode),
        .dwell    (dwell),
        .stop     (stop),
        .D        (D),
        .D_valid  (D_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] line(input int i);
        logic [31:0] one;
        one = 32'h1;
        return one << i;
    endfunction

    function automatic logic [31:0] pin_level(input logic [31:0] active_high);
`ifdef LINE_DEC_ACTIVE_LOW_EN
        return ~active_high;
`else
        return active_high;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic applyStimulus(input logic rs, input logic vld, input logic [4:0] addr,
                                 input logic md, input logic [3:0] dw, input logic stp,
                                 input logic [31:0] exp_d, input logic exp_dv, input logic exp_rdy);
        exp_t e;
        rst      = rs;
        in_valid = vld;
        A        = addr;
        mode     = md;
        dwell    = dw;
        stop     = stp;
        e.d      = exp_d;
        e.dv     = exp_dv;
        e.rdy    = exp_rdy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic rs);
        applyStimulus(rs, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checkOutput("D", D, pin_level(cur.d));
            checkOutput("D_valid", {31'b0, D_valid}, {31'b0, cur.dv});
            checkOutput("in_ready", {31'b0, in_ready}, {31'b0, cur.rdy});
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; mode = 1'b0; dwell = '0; stop = 1'b0;

        idle_cycle(1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // DECODE A=19 dwell=0: single-cycle pulse
        applyStimulus(1'b0, 1'b1, 5'd19, 1'b0, 4'd0, 1'b0, 32'h0008_0000, 1'b1, 1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b0);

        // DECODE A=0 dwell=3 with a second request held during HOLD
        applyStimulus(1'b0, 1'b1, 5'd0, 1'b0, 4'd3, 1'b0, line(0), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 5'd5, 1'b0, 4'd0, 1'b0, line(0), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'd5, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 5'd5, 1'b0, 4'd0, 1'b0, line(5), 1'b1, 1'b0);
        idle_cycle(1'b0);

        // SCAN A=30 dwell=1 across the wrap, then stop mid-dwell
        applyStimulus(1'b0, 1'b1, 5'd30, 1'b1, 4'd1, 1'b0, line(30), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, line(30), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, line(31), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, line(31), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, line(0),  1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, line(0),  1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, line(1),  1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b1, 32'h0,    1'b0, 1'b1);
        idle_cycle(1'b0);

        // SCAN dwell=0: stop coincides with expiry, no advance
        applyStimulus(1'b0, 1'b1, 5'd3, 1'b1, 4'd0, 1'b0, line(3), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, line(4), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b1, 32'h0,   1'b0, 1'b1);

        // stop in IDLE is ignored and does not block a same-cycle accept
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b1, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 5'd10, 1'b0, 4'd1, 1'b1, line(10), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, line(10), 1'b1, 1'b0);
        idle_cycle(1'b0);

        // rst mid-SCAN, then A=7 accepted right after
        applyStimulus(1'b0, 1'b1, 5'd12, 1'b1, 4'd2, 1'b0, line(12), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, line(12), 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd12, 1'b1, 4'd2, 1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 5'd7, 1'b0, 4'd0, 1'b0, line(7), 1'b1, 1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b0);

        @(negedge clk);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
